scratch_pad_port_arbiter: RTL and testbench

Shares one scratch_pad port among REQUESTERS clients using round-robin arbitration. Forwards granted reads and writes to the port through one register stage. Tracks outstanding reads with a credit counter and a requester-ID FIFO, so in-order responses route back to the issuing client. The credit limit keeps the scratch pad reorder queue from overflowing.

---
 rtl/scratch_pad_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_scratch_pad_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_pad_port_arbiter.sv
// Round-robin arbiter sharing one scratch pad port among several clients.
// Granted requests reach the port through one register stage. Outstanding
// reads are bounded by a credit counter, and an ID FIFO records which client
// issued each read so that in-order responses are steered back to it.
module scratch_pad_port_arbiter #(
  parameter int REQUESTERS      = 4,
  parameter int WIDTH           = 64,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_OUTSTANDING = 30,
  parameter int REQ_BITS        = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [0:REQUESTERS-1]            req_rd_en,
  input  logic [0:REQUESTERS-1]            req_wr_en,
  input  logic [ADDR_WIDTH*REQUESTERS-1:0] req_addr,
  input  logic [WIDTH*REQUESTERS-1:0]      req_d,
  output logic [0:REQUESTERS-1]            req_grant,
  output logic [WIDTH-1:0]                 rsp_q,
  output logic [0:REQUESTERS-1]            rsp_valid,
  input  logic [0:REQUESTERS-1]            rsp_stall,
  output logic                             sp_rd_en,
  output logic                             sp_wr_en,
  output logic [ADDR_WIDTH-1:0]            sp_addr,
  output logic [WIDTH-1:0]                 sp_d,
  input  logic                             sp_full,
  input  logic [WIDTH-1:0]                 sp_q,
  input  logic                             sp_valid,
  output logic                             sp_stall,
  output logic                             idle,
  output logic                             error
);

  localparam int PTR_BITS = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(MAX_OUTSTANDING - 1);
  localparam logic [REQ_BITS-1:0] REQ_LAST = REQ_BITS'(REQUESTERS - 1);

  // Issue register stage
  logic                  r_sp_rd_en;
  logic                  r_sp_wr_en;
  logic [ADDR_WIDTH-1:0] r_sp_addr;
  logic [WIDTH-1:0]      r_sp_d;
  logic                  r_error;
  logic [REQ_BITS-1:0]   r_rr_ptr;

  // Outstanding-read tracking
  logic [CNT_BITS-1:0]   r_count;
  logic [PTR_BITS-1:0]   r_wr_ptr;
  logic [PTR_BITS-1:0]   r_rd_ptr;
  logic [REQ_BITS-1:0]   r_id_fifo [MAX_OUTSTANDING];

  logic [ADDR_WIDTH-1:0] w_addr_arr [REQUESTERS];
  logic [WIDTH-1:0]      w_d_arr    [REQUESTERS];
  logic [0:REQUESTERS-1] w_grantable;
  logic [0:REQUESTERS-1] w_grant;
  logic                  w_found;
  logic [REQ_BITS-1:0]   w_gidx;
  logic                  w_at_limit;
  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic                  w_grant_both;
  logic                  w_empty;
  logic [REQ_BITS-1:0]   w_head;
  logic                  w_head_stall;
  logic                  w_pop;

  assign w_at_limit = (r_count == CNT_MAX);
  assign w_empty    = (r_count == '0);

  // A read-only client waits at the credit limit; anything carrying a write
  // (including a malformed read+write) still goes out as a write.
  genvar gi;
  generate
    for (gi = 0; gi < REQUESTERS; gi++) begin : g_client
      assign w_addr_arr[gi]  = req_addr[(REQUESTERS-gi-1)*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_d_arr[gi]     = req_d[(REQUESTERS-gi-1)*WIDTH +: WIDTH];
      assign w_grantable[gi] = (req_rd_en[gi] | req_wr_en[gi]) & ~sp_full &
                               ~(req_rd_en[gi] & ~req_wr_en[gi] & w_at_limit);
    end
  endgenerate

  // Round-robin scan starting at the pointer, wrapping around the clients
  always_comb begin
    int scan_idx;
    scan_idx = 0;
    w_found  = 1'b0;
    w_gidx   = '0;
    w_grant  = '0;
    for (int off = 0; off < REQUESTERS; off++) begin
      scan_idx = (int'(r_rr_ptr) + off) % REQUESTERS;
      if (!w_found && w_grantable[scan_idx]) begin
        w_found = 1'b1;
        w_gidx  = REQ_BITS'(scan_idx);
      end
    end
    if (w_found && !rst) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign w_grant_wr   = w_found && req_wr_en[w_gidx];
  assign w_grant_rd   = w_found && req_rd_en[w_gidx] && !req_wr_en[w_gidx];
  assign w_grant_both = w_found && req_rd_en[w_gidx] && req_wr_en[w_gidx];

  assign w_head       = r_id_fifo[r_rd_ptr];
  assign w_head_stall = !w_empty && rsp_stall[w_head];
  assign w_pop        = sp_valid && !w_empty && !rsp_stall[w_head];

  // Steer the response valid to the client that issued the oldest read
  always_comb begin
    rsp_valid = '0;
    if (sp_valid && !w_empty && !rst) begin
      rsp_valid[w_head] = 1'b1;
    end
  end

  // Register the granted request towards the scratch pad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp_rd_en <= 1'b0;
      r_sp_wr_en <= 1'b0;
      r_sp_addr  <= '0;
      r_sp_d     <= '0;
    end else begin
      r_sp_rd_en <= w_grant_rd;
      r_sp_wr_en <= w_grant_wr;
      if (w_found) begin
        r_sp_addr <= w_addr_arr[w_gidx];
        r_sp_d    <= w_d_arr[w_gidx];
      end
    end
  end

  // Advance the round-robin pointer past the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= (w_gidx == REQ_LAST) ? '0 : w_gidx + 1'b1;
    end
  end

  // ID FIFO storage; contents need no reset since the pointers gate them
  always_ff @(posedge clk) begin
    if (w_grant_rd) begin
      r_id_fifo[r_wr_ptr] <= w_gidx;
    end
  end

  // Credit counter and FIFO pointers; push and pop may coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_grant_rd) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_grant_rd, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky protocol error: read+write on one client, or an unrequested response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (w_grant_both || (sp_valid && w_empty)) begin
      r_error <= 1'b1;
    end
  end

  assign req_grant = w_grant;
  assign rsp_q     = sp_q;
  assign sp_stall  = w_head_stall;
  assign sp_rd_en  = r_sp_rd_en;
  assign sp_wr_en  = r_sp_wr_en;
  assign sp_addr   = r_sp_addr;
  assign sp_d      = r_sp_d;
  assign error     = r_error;
  assign idle      = w_empty && !r_sp_rd_en && !r_sp_wr_en;

endmodule

// File: tb/tb_scratch_pad_port_arbiter.sv
// Bench for scratch_pad_port_arbiter: directed stimulus pushes expected port
// issues and expected client responses into queues; a monitor pops and
// compares them whenever the DUT presents an issue or an accepted response.
module tb_scratch_pad_port_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int AW = 12;
  localparam int MO = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [0:N-1]    req_rd_en, req_wr_en, req_grant, rsp_valid, rsp_stall;
  logic [AW*N-1:0] req_addr;
  logic [W*N-1:0]  req_d;
  logic [W-1:0]    rsp_q, sp_d, sp_q;
  logic [AW-1:0]   sp_addr;
  logic            sp_rd_en, sp_wr_en, sp_full, sp_valid, sp_stall, idle, error;

  scratch_pad_port_arbiter #(
    .REQUESTERS(N), .WIDTH(W), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .req_addr(req_addr), .req_d(req_d), .req_grant(req_grant),
    .rsp_q(rsp_q), .rsp_valid(rsp_valid), .rsp_stall(rsp_stall),
    .sp_rd_en(sp_rd_en), .sp_wr_en(sp_wr_en), .sp_addr(sp_addr), .sp_d(sp_d),
    .sp_full(sp_full), .sp_q(sp_q), .sp_valid(sp_valid), .sp_stall(sp_stall),
    .idle(idle), .error(error)
  );

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  d;
  } issue_t;

  typedef struct packed {
    logic [0:N-1] v;
    logic [W-1:0] q;
  } rsp_t;

  issue_t iss_q[$];
  rsp_t   rsp_exp_q[$];
  issue_t mon_iss;
  rsp_t   mon_rsp;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[(N-1-i)*AW +: AW] = a;
  endtask

  task automatic set_d(input int i, input logic [W-1:0] v);
    req_d[(N-1-i)*W +: W] = v;
  endtask

  function automatic logic [AW-1:0] get_addr(input int i);
    return req_addr[(N-1-i)*AW +: AW];
  endfunction

  function automatic logic [W-1:0] get_d(input int i);
    return req_d[(N-1-i)*W +: W];
  endfunction

  // Expect a port issue one cycle after a grant to client i
  task automatic expect_issue(input int i, input logic is_wr);
    iss_q.push_back({~is_wr, is_wr, get_addr(i), get_d(i)});
  endtask

  function automatic logic [0:N-1] onehot(input int i);
    logic [0:N-1] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: compare every port issue and every accepted response beat
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (sp_rd_en || sp_wr_en) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("FAIL issue: got rd=%0b wr=%0b addr=%0h with none expected",
                   sp_rd_en, sp_wr_en, sp_addr);
        end else begin
          mon_iss = iss_q.pop_front();
          if ({sp_rd_en, sp_wr_en, sp_addr, sp_d} !== mon_iss) begin
            errors++;
            $display("FAIL issue: got rd=%0b wr=%0b addr=%0h d=%0h expected rd=%0b wr=%0b addr=%0h d=%0h",
                     sp_rd_en, sp_wr_en, sp_addr, sp_d,
                     mon_iss.rd, mon_iss.wr, mon_iss.addr, mon_iss.d);
          end else begin
            $display("issue rd=%0b wr=%0b addr=%0h d=%0h ok",
                     sp_rd_en, sp_wr_en, sp_addr, sp_d);
          end
        end
      end
      if ((rsp_valid & ~rsp_stall) != '0) begin
        checks++;
        if (rsp_exp_q.size() == 0) begin
          errors++;
          $display("FAIL response: got valid=%b q=%0h with none expected", rsp_valid, rsp_q);
        end else begin
          mon_rsp = rsp_exp_q.pop_front();
          if ({rsp_valid, rsp_q} !== mon_rsp) begin
            errors++;
            $display("FAIL response: got valid=%b q=%0h expected valid=%b q=%0h",
                     rsp_valid, rsp_q, mon_rsp.v, mon_rsp.q);
          end else begin
            $display("response valid=%b q=%0h ok", rsp_valid, rsp_q);
          end
        end
      end
    end
  end

  initial begin
    req_rd_en = '0; req_wr_en = '0; req_addr = '0; req_d = '0;
    rsp_stall = '0; sp_full = 1'b0; sp_q = '0; sp_valid = 1'b0;
    #1 rst = 1'b1;
    // Reset state, with every client already requesting
    req_rd_en = 4'b1111;
    set_addr(0, 12'h010); set_addr(1, 12'h020); set_addr(2, 12'h030); set_addr(3, 12'h040);
    #2;
    check("reset_grant", req_grant, 4'b0000);
    check("reset_sp_rd_en", sp_rd_en, 0);
    check("reset_idle", idle, 1);
    check("reset_error", error, 0);
    step();
    rst = 1'b0;

    // Round robin over four reading clients, then in-order responses
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("rr_grant", req_grant, onehot(k));
      expect_issue(k, 1'b0);
      step();
      req_rd_en[k] = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      sp_valid = 1'b1;
      sp_q = 64'hD0 + 64'(k);
      rsp_exp_q.push_back({onehot(k), sp_q});
      @(negedge clk);
      step();
    end
    sp_valid = 1'b0;
    @(negedge clk);
    check("idle_after_rr", idle, 1);

    // Write held off by sp_full
    step();
    sp_full = 1'b1;
    req_wr_en[2] = 1'b1;
    set_addr(2, 12'h005);
    set_d(2, 64'hAB);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_no_grant", req_grant, 4'b0000);
      step();
    end
    sp_full = 1'b0;
    @(negedge clk);
    check("full_release_grant", req_grant, onehot(2));
    expect_issue(2, 1'b1);
    step();
    req_wr_en[2] = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    check("hold_wr_en", sp_wr_en, 0);
    check("hold_addr", sp_addr, 64'h5);
    check("hold_d", sp_d, 64'hAB);

    // Credit limit: 30 reads from client 0
    step();
    req_rd_en[0] = 1'b1;
    for (int n = 0; n < MO; n++) begin
      set_addr(0, 12'h100 + 12'(n));
      @(negedge clk);
      check("credit_fill_grant", req_grant, onehot(0));
      expect_issue(0, 1'b0);
      step();
    end
    req_wr_en[1] = 1'b1;
    set_addr(1, 12'h077);
    set_d(1, 64'h1234);
    @(negedge clk);
    check("limit_write_grant", req_grant, onehot(1));
    expect_issue(1, 1'b1);
    step();
    req_wr_en[1] = 1'b0;
    @(negedge clk);
    check("limit_read_blocked", req_grant, 4'b0000);
    check("limit_not_idle", idle, 0);
    step();
    sp_valid = 1'b1;
    sp_q = 64'hE0;
    rsp_exp_q.push_back({onehot(0), sp_q});
    @(negedge clk);
    check("limit_pop_same_cycle", req_grant, 4'b0000);
    step();
    sp_valid = 1'b0;
    set_addr(0, 12'h200);
    @(negedge clk);
    check("limit_regrant", req_grant, onehot(0));
    expect_issue(0, 1'b0);
    step();
    req_rd_en[0] = 1'b0;
    for (int n = 0; n < MO; n++) begin
      sp_valid = 1'b1;
      sp_q = 64'hF00 + 64'(n);
      rsp_exp_q.push_back({onehot(0), sp_q});
      @(negedge clk);
      step();
    end
    sp_valid = 1'b0;
    @(negedge clk);
    check("idle_after_drain", idle, 1);

    // Stalled response for client 3
    step();
    req_rd_en[3] = 1'b1;
    set_addr(3, 12'h033);
    @(negedge clk);
    check("stall_read_grant", req_grant, onehot(3));
    expect_issue(3, 1'b0);
    step();
    req_rd_en[3] = 1'b0;
    sp_valid = 1'b1;
    sp_q = 64'h3333;
    rsp_stall[3] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall_sp_stall", sp_stall, 1);
      check("stall_rsp_valid", rsp_valid, onehot(3));
      check("stall_not_idle", idle, 0);
      step();
    end
    rsp_stall[3] = 1'b0;
    rsp_exp_q.push_back({onehot(3), sp_q});
    @(negedge clk);
    check("unstall_sp_stall", sp_stall, 0);
    step();
    sp_valid = 1'b0;
    @(negedge clk);
    check("stall_pop_idle", idle, 1);

    // Unrequested response sets the sticky error
    check("error_clear_before", error, 0);
    step();
    sp_valid = 1'b1;
    sp_q = 64'hBAD;
    @(negedge clk);
    check("orphan_rsp_valid", rsp_valid, 4'b0000);
    step();
    sp_valid = 1'b0;
    @(negedge clk);
    check("orphan_error", error, 1);
    repeat (3) step();
    @(negedge clk);
    check("error_sticky", error, 1);

    // Reset with five reads in flight
    step();
    req_rd_en[2] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      set_addr(2, 12'h060 + 12'(n));
      @(negedge clk);
      check("inflight_grant", req_grant, onehot(2));
      expect_issue(2, 1'b0);
      step();
    end
    req_rd_en[2] = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    req_rd_en[1] = 1'b1;
    req_rd_en[3] = 1'b1;
    sp_valid = 1'b1;
    #1;
    check("async_rst_rd_en", sp_rd_en, 0);
    check("async_rst_addr", sp_addr, 0);
    check("async_rst_d", sp_d, 0);
    check("async_rst_error", error, 0);
    check("async_rst_grant", req_grant, 4'b0000);
    check("async_rst_rsp_valid", rsp_valid, 4'b0000);
    sp_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", idle, 1);
    check("post_rst_first_grant", req_grant, onehot(1));
    expect_issue(1, 1'b0);
    step();
    req_rd_en[1] = 1'b0;
    @(negedge clk);
    check("post_rst_second_grant", req_grant, onehot(3));
    expect_issue(3, 1'b0);
    step();
    req_rd_en[3] = 1'b0;
    repeat (2) step();

    check("issues_left", iss_q.size(), 0);
    check("responses_left", rsp_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
